// File: rtl/frame_sender.sv
// Streams a frame buffer to the PE stage in raster order through a 2-entry skid FIFO.
// Optional macro SEND_ZERO_PAD_EN adds a one-pixel zero border around the image.
module frame_sender #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              state_send,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done_send
);

`ifdef SEND_ZERO_PAD_EN
    localparam int ROWS = IMG_H + 2;
    localparam int COLS = IMG_W + 2;
`else
    localparam int ROWS = IMG_H;
    localparam int COLS = IMG_W;
`endif
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [DATA_W-1:0] fifo_data [2];
    logic              fifo_last [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              inflight, inflight_last;
    logic              issue, last_pos, pop, push;
    logic [2:0]        occ_eff;
    logic [ADDR_W-1:0] lin_addr;

    // Outputs are gated by reset so they are already quiet in the cycle reset is first seen.
    assign out_valid = !reset && (count != 2'd0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign done_send = !reset && (state == DONE);

    assign pop  = out_valid && out_ready;
    assign push = inflight;

    // Counting the beat leaving this cycle is what allows one issue per cycle at full rate.
    assign occ_eff  = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue    = !reset && (state == RUN) && (occ_eff < 3'd2);
    assign last_pos = (row == ROW_LAST) && (col == COL_LAST);

`ifdef SEND_ZERO_PAD_EN
    logic is_pad, inflight_pad;
    assign is_pad   = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
    assign lin_addr = ADDR_W'(row - RW'(1)) * ADDR_W'(IMG_W) + ADDR_W'(col - CW'(1));
    assign mem_rd   = issue && !is_pad;
`else
    assign lin_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    assign mem_rd   = issue;
`endif
    assign mem_addr = mem_rd ? lin_addr : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default first so no path through this block infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (state_send) state_next = RUN;
            RUN:     if (issue && last_pos) state_next = DRAIN;
            DRAIN:   if (pop && out_last) state_next = DONE;
            DONE:    state_next = HOLD;
            HOLD:    if (!state_send) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row           <= '0;
            col           <= '0;
            count         <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
`ifdef SEND_ZERO_PAD_EN
            inflight_pad  <= 1'b0;
`endif
        end else begin
            if (issue) begin
                if (last_pos) begin
                    row <= '0;
                    col <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            inflight      <= issue;
            inflight_last <= issue && last_pos;
`ifdef SEND_ZERO_PAD_EN
            inflight_pad  <= issue && is_pad;
`endif
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is, and out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
`ifdef SEND_ZERO_PAD_EN
            fifo_data[wr_ptr] <= inflight_pad ? '0 : mem_rdata;
`else
            fifo_data[wr_ptr] <= mem_rdata;
`endif
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

endmodule
